mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage load/store engine that consumes the registered execute-to-memory control word (load control, store control) together with the M-stage address and store data. It converts each access into a single-outstanding data-bus transaction with byte enables, stalls the pipeline until the bus acknowledges, and returns sign- or zero-extended load data for writeback. Misaligned accesses and bus timeouts are reported as one-cycle exception pulses.

## Interface
- TIMEOUT, default 255: max cycles bus_req may wait for bus_ack before abort (1..255).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- valid_m  in  1  M-stage holds a live instruction.
- rd_ctrl_m  in  3  load type: 000 LB, 001 LH, 010 LW, 011 none, 100 LBU, 101 LHU, others none.
- wr_ctrl_m  in  3  store type: 000 SB, 001 SH, 010 SW, 111 none, others none.
- addr_m  in  32  byte address from ALU.
- wdata_m  in  32  store source register value.
- bus_req  out  1  transaction request, held until bus_ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address (addr_m with [1:0] = 00).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-aligned store data.
- bus_ack  in  1  one-cycle completion; bus_rdata valid same cycle.
- bus_rdata  in  32  read word.
- load_data_m  out  32  extended load result.
- stall_m  out  1  hold F/D/E/M stages this cycle.
- misalign_exc  out  1  one-cycle misalignment pulse.
- bus_err  out  1  one-cycle timeout pulse.

## Operation
- Access = valid_m and (load type valid or store type valid). Store and load both valid: store wins, load ignored, load_data_m = 0.
- Alignment: halfword needs addr_m[0]=0; word needs addr_m[1:0]=00. Misaligned: no bus activity, misalign_exc=1 for that cycle, stall_m=0, FSM stays IDLE.
- States: IDLE, REQ, RESP.
- IDLE: aligned access -> stall_m=1 (combinational), latch bus_addr/bus_be/bus_wdata/bus_we and type, counter=0, go REQ.
- REQ: bus_req=1, stall_m=1, outputs stable. bus_ack -> capture bus_rdata, go RESP. Else counter+1; counter==TIMEOUT-1 with no ack -> bus_err=1 next cycle in RESP, load result 0, bus_req drops.
- RESP: stall_m=0, load_data_m valid, go IDLE unconditionally (pipeline advances at end of RESP; no relaunch).
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
- Load extract: select lane by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
- load_data_m = 0 whenever not in RESP or for store/error.
- bus_ack outside REQ ignored.

## Timing
- Reset: state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data_m=0, stall_m=0, misalign_exc=0, bus_err=0, counter=0.
- Reset during REQ: bus_req=0 after the reset edge; pending ack discarded.
- Min latency: access seen cycle 0 (IDLE), bus_req cycle 1, ack cycle 1, RESP cycle 2; instruction occupies M for 3 cycles.
- Each extra ack wait cycle adds one stall cycle.
- bus_req never deasserts in REQ before bus_ack or timeout; bus_addr/be/wdata/we constant while bus_req=1.
- Timeout: ack absent for TIMEOUT cycles of REQ -> RESP with bus_err=1; ack on the final counted cycle wins over timeout.

## Test plan
- LW addr 0x100, ack cycle 1 with rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, stall 2 cycles, load_data_m 0xDEADBEEF in RESP.
- LB addr 0x203, rdata 0x80FF_0000 -> be 1000, load_data_m 0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr 0x302, wdata 0x1234ABCD, ack after 3 waits -> bus_we=1, be 1100, bus_wdata 0xABCDABCD, stall 5 cycles total.
- LW addr 0x101 -> misalign_exc pulse, bus_req never asserts, stall_m=0.
- TIMEOUT=4, SW with no ack -> bus_req high 4 cycles, then bus_err pulse, stall released, IDLE.
- Reset asserted mid-REQ -> next edge bus_req=0, stall_m=0, all outputs at reset values; later ack ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one outstanding bus transaction per M-stage access.
// Latency: access seen in IDLE, bus_req next cycle, result in RESP one cycle after bus_ack (min 3 cycles in M).
// Backpressure: stall_m holds the pipeline from launch until bus_ack or timeout; misaligned accesses never stall.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_m,
  input  logic [2:0]  rd_ctrl_m,
  input  logic [2:0]  wr_ctrl_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data_m,
  output logic        stall_m,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last counted REQ cycle before the request is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] load_data_q;
  logic        bus_err_q;
  logic [1:0]  lo_q;        // byte offset of the access, kept for lane selection
  logic [1:0]  size_q;      // 00 byte, 01 half, 10 word
  logic        uns_q;       // zero-extend the load result
  logic        is_ld_q;     // transaction returns data to writeback

  logic        ld_vld;
  logic        st_vld;
  logic        access;
  logic [1:0]  size_d;
  logic        aligned;
  logic        launch;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_d;
  logic [31:0] rsh;

  // Decode the control word; a valid store takes precedence over a load.
  always_comb begin
    ld_vld  = rd_ctrl_m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_vld  = wr_ctrl_m inside {3'b000, 3'b001, 3'b010};
    access  = valid_m && (ld_vld || st_vld);
    size_d  = st_vld ? wr_ctrl_m[1:0] : rd_ctrl_m[1:0];
    case (size_d)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !addr_m[0];
      2'b10:   aligned = (addr_m[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    launch       = rst_n && (state_q == IDLE) && access && aligned;
    misalign_exc = rst_n && (state_q == IDLE) && access && !aligned;
    stall_m      = rst_n && ((state_q == REQ) || launch);
  end

  // Byte enables and lane-replicated store data for the access being launched.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    case (size_d)
      2'b00: begin
        be_d    = 4'b0001 << addr_m[1:0];
        wdata_d = {4{wdata_m[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr_m[1], 1'b0};
        wdata_d = {2{wdata_m[15:0]}};
      end
      2'b10: begin
        be_d    = 4'b1111;
        wdata_d = wdata_m;
      end
      default: begin
        be_d    = 4'b0000;
        wdata_d = 32'h0;
      end
    endcase
    if (!st_vld) wdata_d = 32'h0;
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    rsh   = bus_rdata >> {lo_q, 3'b000};
    ext_d = 32'h0;
    case (size_q)
      2'b00:   ext_d = uns_q ? {24'h0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]};
      2'b01: begin
        if (lo_q[1]) ext_d = uns_q ? {16'h0, bus_rdata[31:16]} : {{16{bus_rdata[31]}}, bus_rdata[31:16]};
        else         ext_d = uns_q ? {16'h0, bus_rdata[15:0]}  : {{16{bus_rdata[15]}}, bus_rdata[15:0]};
      end
      2'b10:   ext_d = bus_rdata;
      default: ext_d = 32'h0;
    endcase
  end

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
      bus_err_q   <= 1'b0;
      lo_q        <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      is_ld_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= st_vld;
            bus_addr_q  <= {addr_m[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            lo_q        <= addr_m[1:0];
            size_q      <= size_d;
            uns_q       <= rd_ctrl_m[2];
            is_ld_q     <= !st_vld;
            cnt_q       <= 8'h0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // An ack on the last counted cycle still completes normally.
          if (bus_ack) begin
            bus_req_q   <= 1'b0;
            load_data_q <= is_ld_q ? ext_d : 32'h0;
            state_q     <= RESP;
          end else if (cnt_q == TO_LAST) begin
            bus_req_q   <= 1'b0;
            bus_err_q   <= 1'b1;
            load_data_q <= 32'h0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        RESP: begin
          bus_err_q   <= 1'b0;
          load_data_q <= 32'h0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign load_data_m = load_data_q;
  assign bus_err     = bus_err_q;

endmodule
